touch_key_debounce: RTL and testbench
=====================================

// Module: touch_key_debounce
// PURPOSE
//  Conditions the raw touch-sensor output before touch_ctrl_led consumes it.
//  - Synchronises the asynchronous touch_key pin and rejects bounce and glitches.
//  - Emits a debounced level plus one-cycle press, release and (optional) long-press pulses.
//  - touch_ctrl_led toggles its LED on key_press and needs no edge logic of its own.
// PARAMETERS
//  KEY_ACTIVE    1'b0        pin level meaning "touched" (pin idles at ~KEY_ACTIVE)
//  DEBOUNCE_CNT  999_999     consecutive stable cycles needed to accept a level change (20 ms @ 50 MHz); >=1
//  LONG_CNT      49_999_999  PRESSED cycles after key_press before long_press fires (1 s @ 50 MHz); >=1
// PORTS
//  sys_clk      in   1  system clock; all logic on its rising edge
//  sys_rst_n    in   1  reset, synchronous, active-low
//  touch_key    in   1  raw touch pin, asynchronous to sys_clk
//  key_state    out  1  debounced level, 1 = touched
//  key_press    out  1  one-cycle pulse when a touch is accepted
//  key_release  out  1  one-cycle pulse when a release is accepted
//  long_press   out  1  one-cycle pulse when a hold reaches LONG_CNT (LONG_PRESS_EN only)
// BEHAVIOUR
//  - Reset (sys_rst_n==0 at a rising edge):
//    - both synchroniser flops load ~KEY_ACTIVE
//    - FSM -> IDLE; all counters -> 0
//    - every output registered and reset to 0
//  - Synchroniser: two flops, key_s = (sync2 == KEY_ACTIVE).
//  - FSM states IDLE, PRESS_FILT, PRESSED, RELEASE_FILT:
//    - IDLE: key_s==1 -> PRESS_FILT, cnt=1; otherwise stay, cnt=0.
//    - PRESS_FILT: key_s==0 -> IDLE, cnt=0 (glitch rejected, no pulse).
//      key_s==1 and cnt==DEBOUNCE_CNT -> PRESSED; else cnt+1.
//    - PRESSED: key_s==0 -> RELEASE_FILT, cnt=1; otherwise stay.
//    - RELEASE_FILT: key_s==1 -> PRESSED, cnt=0.
//      key_s==0 and cnt==DEBOUNCE_CNT -> IDLE; else cnt+1.
//  - Outputs:
//    - key_state=1 exactly while FSM is PRESSED or RELEASE_FILT.
//    - key_press=1 for the single cycle after the PRESS_FILT->PRESSED transition edge.
//    - key_release=1 for the single cycle after the RELEASE_FILT->IDLE transition edge.
//  - Latency: a clean level change first sampled at edge k gives the output change at edge k+DEBOUNCE_CNT+2.
//  - Any bounce restarts filtering.
//    - A changed level shorter than DEBOUNCE_CNT cycles produces no pulse and no key_state change.
//  - Counters:
//    - width $clog2(max(DEBOUNCE_CNT,LONG_CNT)+1), unsigned.
//    - The debounce counter never exceeds DEBOUNCE_CNT.
//  - Reset mid-operation: outputs drop to 0 at that edge.
//    - No key_release is emitted for a press aborted by reset.
//    - After reset, a pin already held touched is accepted as a fresh press after the full filter time.
//  - key_press and key_release are never high in the same cycle.
//  - At most one press pulse per accepted release and vice versa.
// CONFIGURATION
//  LONG_PRESS_EN defined:
//   - Hold counter: cleared on entering PRESSED from PRESS_FILT; counts in PRESSED and RELEASE_FILT.
//   - long_press pulses once when the hold counter reaches LONG_CNT, then the counter saturates
//     (no repeat until a new key_press).
//   - A release accepted before LONG_CNT gives no long_press.
//   - Return from RELEASE_FILT to PRESSED does not clear the hold counter.
//  LONG_PRESS_EN undefined: hold counter not built; long_press tied to 0.
// TESTING  (DEBOUNCE_CNT=10, LONG_CNT=50, KEY_ACTIVE=0, 20 ns clock)
//  - Reset:
//    - stimulus: sys_rst_n=0 for 50 cycles while touch_key toggles every 3 cycles
//    - required: all outputs 0 throughout
//  - Glitch:
//    - stimulus: touch_key=0 for 5 cycles, then 1
//    - required: key_press, key_state and key_release stay 0
//  - Clean press:
//    - stimulus: touch_key=0 for 100 cycles
//    - required: exactly 1 key_press, 12 edges after the first low sample; key_state=1
//    - required (macro on): 1 long_press 50 cycles after key_press
//    - stimulus: release
//    - required: 1 key_release 12 edges later
//  - Bouncy release:
//    - stimulus: while pressed, touch_key toggles at 3-cycle intervals 4 times, then stays 1
//    - required: exactly 1 key_release; no extra key_press
//  - Short hold:
//    - stimulus: press held 30 cycles, then release
//    - required: key_press and key_release each once; long_press never asserted
//  - Reset mid-press:
//    - stimulus: sys_rst_n=0 for 1 cycle in PRESSED, touch_key still 0
//    - required: key_state=0 at that edge; no key_release; new key_press 12 edges after reset release
//    - required (macro off): long_press stays 0 across all scenarios

Source files
------------

// File: rtl/touch_key_debounce.sv
// touch_key_debounce: synchronises and debounces a touch pin into a level plus press/release pulses.
// Optional long-press pulse is built only when LONG_PRESS_EN is defined.
module touch_key_debounce #(
    parameter logic KEY_ACTIVE   = 1'b0,
    parameter int   DEBOUNCE_CNT = 999_999,
    parameter int   LONG_CNT     = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic touch_key,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic long_press
);
    localparam int MAX_CNT = DEBOUNCE_CNT > LONG_CNT ? DEBOUNCE_CNT : LONG_CNT;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {IDLE, PRESS_FILT, PRESSED, RELEASE_FILT} state_t;

    state_t state;
    logic sync1, sync2, key_s;
    logic [CW-1:0] cnt;
    logic press_accept;

    assign key_s = sync2 == KEY_ACTIVE;
    assign press_accept = state == PRESS_FILT && key_s && cnt == DEB;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1       <= ~KEY_ACTIVE;
            sync2       <= ~KEY_ACTIVE;
            state       <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= touch_key;
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: begin
                    state <= key_s ? PRESS_FILT : IDLE;
                    cnt   <= key_s ? CW'(1) : '0;
                end
                PRESS_FILT: begin
                    if (!key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        key_state <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!key_s) begin
                        state <= RELEASE_FILT;
                        cnt   <= CW'(1);
                    end
                end
                RELEASE_FILT: begin
                    if (key_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam logic [CW-1:0] LNG = CW'(LONG_CNT);
    logic [CW-1:0] hold;

    // hold saturates at LNG so the pulse fires once per accepted press
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (press_accept) begin
                hold <= '0;
            end else if ((state == PRESSED || state == RELEASE_FILT) && hold != LNG) begin
                hold       <= hold + 1'b1;
                long_press <= hold == LNG - 1'b1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = press_accept;
    assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_touch_key_debounce.sv
// tb_touch_key_debounce: table-driven directed check of touch_key_debounce (DEBOUNCE_CNT=10, LONG_CNT=50).
module tb_touch_key_debounce;
`ifdef LONG_PRESS_EN
    localparam int LP = 1;
`else
    localparam int LP = 0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n, touch_key;
    logic key_state, key_press, key_release, long_press;

    touch_key_debounce #(.KEY_ACTIVE(1'b0), .DEBOUNCE_CNT(10), .LONG_CNT(50)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .touch_key(touch_key),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .long_press(long_press)
    );

    always #10 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    int pulse_cyc = 0, press_cyc = 0, long_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (key_press) begin
            n_press++;
            pulse_cyc = cyc;
            press_cyc = cyc;
        end
        if (key_release) begin
            n_rel++;
            pulse_cyc = cyc;
        end
        if (long_press) begin
            n_long++;
            long_cyc = cyc;
        end
        if (sys_rst_n === 1'b1) begin
            checks++;
            if (key_press && key_release) begin
                errors++;
                $display("FAIL press_release_overlap at cycle %0d: both high", cyc);
            end
        end
    end

    typedef struct {
        bit rst_n;
        bit key;
        int ncyc;
        bit st;
        int np;
        int nr;
        int nl;
        int at;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int s, p0, r0, l0;
        // rst_n key cycles | key_state press release long pulse_offset
        vecs[0]  = '{1, 1, 20,  0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 5,   0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 20,  0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 100, 1, 1, 0, 1, 13};
        vecs[4]  = '{1, 1, 30,  0, 0, 1, 0, 13};
        vecs[5]  = '{1, 0, 30,  1, 1, 0, 0, 13};
        vecs[6]  = '{1, 1, 3,   1, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 3,   1, 0, 0, 0, 0};
        vecs[8]  = '{1, 1, 3,   1, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 3,   1, 0, 0, 0, 0};
        vecs[10] = '{1, 1, 30,  0, 0, 1, 0, 13};
        vecs[11] = '{1, 0, 30,  1, 1, 0, 0, 13};
        vecs[12] = '{1, 1, 30,  0, 0, 1, 0, 13};
        vecs[13] = '{1, 0, 30,  1, 1, 0, 0, 13};
        vecs[14] = '{0, 0, 1,   0, 0, 0, 0, 0};
        vecs[15] = '{1, 0, 11,  0, 0, 0, 0, 0};
        vecs[16] = '{1, 0, 1,   0, 0, 0, 0, 0};
        vecs[17] = '{1, 0, 1,   1, 1, 0, 0, 1};
        vecs[18] = '{1, 1, 30,  0, 0, 1, 0, 13};

        sys_rst_n = 1'b0;
        touch_key = 1'b1;
        @(negedge sys_clk);
        #1;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) touch_key = ~touch_key;
            @(negedge sys_clk);
            #1;
            check("reset_outputs", {key_state, key_press, key_release, long_press}, 0);
        end
        touch_key = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            sys_rst_n = vecs[i].rst_n;
            touch_key = vecs[i].key;
            s  = cyc;
            p0 = n_press;
            r0 = n_rel;
            l0 = n_long;
            repeat (vecs[i].ncyc) @(negedge sys_clk);
            #1;
            check($sformatf("v%0d key_state", i), int'(key_state), int'(vecs[i].st));
            check($sformatf("v%0d press_count", i), n_press - p0, vecs[i].np);
            check($sformatf("v%0d release_count", i), n_rel - r0, vecs[i].nr);
            check($sformatf("v%0d long_count", i), n_long - l0, vecs[i].nl * LP);
            if (vecs[i].at != 0)
                check($sformatf("v%0d pulse_latency", i), pulse_cyc - s, vecs[i].at);
            if (LP == 1 && vecs[i].nl != 0)
                check($sformatf("v%0d long_latency", i), long_cyc - press_cyc, 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
